dtc_seq_eval: RTL and testbench

- Programmable, sequential successor to the fixed combinational decision-tree classifiers.
- A node table held in registers is loaded through a config write port.
- Each accepted feature vector walks the tree one level per clock, then the leaf class is returned over a valid/ready output handshake.
- It sits between the feature-extraction stage and the class consumer. Width, class size, table size and depth limit are all parametrised.

---
 rtl/dtc_seq_eval.sv | 151 +++++++++++++++
 tb/tb_dtc_seq_eval.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_seq_eval.sv
// dtc_seq_eval: register-based decision tree walked one level per clock.
// The node table is loaded through a config port while idle. Each accepted
// feature vector is walked from the root at address 0, and the leaf class
// (or an abort flag) is presented over a valid/ready handshake.
module dtc_seq_eval #(
  parameter int  INPUT_WIDTH = 8,
  parameter int  CLASS_WIDTH = 2,
  parameter int  MAX_NODES   = 32,
  parameter int  MAX_DEPTH   = 8,
  localparam int FW          = $clog2(INPUT_WIDTH),
  localparam int AW          = $clog2(MAX_NODES),
  localparam int NODE_W      = 1 + FW + 2*AW + CLASS_WIDTH,
  localparam int DW          = $clog2(MAX_DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [NODE_W-1:0]      cfg_data,
  output logic                   cfg_busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] inp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLASS_WIDTH-1:0] out_class,
  output logic                   out_err,
  output logic [DW-1:0]          out_depth
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NODE_W-1:0]        node_tab [MAX_NODES];
  logic [INPUT_WIDTH-1:0]   inp_q;
  logic [AW-1:0]            ptr_q, ptr_d;
  logic [DW-1:0]            depth_q, depth_d;

  logic [NODE_W-1:0]        node;
  logic                     n_leaf;
  logic [FW-1:0]            n_feat;
  logic [AW-1:0]            n_c1, n_c0;
  logic [CLASS_WIDTH-1:0]   n_cls;
  logic                     ptr_bad, feat_ok, sel_bit, depth_max;
  logic                     accept, load_out, res_err;
  logic [CLASS_WIDTH-1:0]   res_cls;

  assign in_ready  = (state_q == IDLE);
  assign cfg_busy  = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && (state_q == IDLE);

  // Decode the node currently addressed by the walk pointer
  always_comb begin
    node    = '0;
    ptr_bad = ({1'b0, ptr_q} >= (AW+1)'(MAX_NODES));
    if (!ptr_bad) node = node_tab[ptr_q];
    n_leaf    = node[NODE_W-1];
    n_feat    = node[NODE_W-2 -: FW];
    n_c1      = node[2*AW+CLASS_WIDTH-1 -: AW];
    n_c0      = node[AW+CLASS_WIDTH-1 -: AW];
    n_cls     = node[CLASS_WIDTH-1:0];
    feat_ok   = ({1'b0, n_feat} < (FW+1)'(INPUT_WIDTH));
    sel_bit   = feat_ok ? inp_q[n_feat] : 1'b0;
    depth_max = (depth_q == DW'(MAX_DEPTH));
  end

  // Next-state and walk-step logic; abort checks are prioritised bad pointer, leaf, depth
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    depth_d  = depth_q;
    load_out = 1'b0;
    res_cls  = '0;
    res_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = WALK;
          ptr_d   = '0;
          depth_d = '0;
        end
      end
      WALK: begin
        if (ptr_bad) begin
          state_d  = DONE;
          load_out = 1'b1;
          res_err  = 1'b1;
        end else if (n_leaf) begin
          state_d  = DONE;
          load_out = 1'b1;
          res_cls  = n_cls;
        end else if (depth_max) begin
          state_d  = DONE;
          load_out = 1'b1;
          res_err  = 1'b1;
        end else begin
          ptr_d   = sel_bit ? n_c1 : n_c0;
          depth_d = depth_q + DW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Walk datapath: captured features, pointer and depth counter
  always_ff @(posedge clk) begin
    if (rst) begin
      inp_q   <= '0;
      ptr_q   <= '0;
      depth_q <= '0;
    end else begin
      if (accept) inp_q <= inp;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
    end
  end

  // Result registers, loaded only on entry to DONE so they hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_class <= '0;
      out_err   <= 1'b0;
      out_depth <= '0;
    end else if (load_out) begin
      out_class <= res_cls;
      out_err   <= res_err;
      out_depth <= depth_q;
    end
  end

  // Node table: reset to leaf/class 0, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_NODES; i++)
        node_tab[i] <= {1'b1, {(NODE_W-1){1'b0}}};
    end else if (cfg_we && (state_q == IDLE)) begin
      node_tab[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_dtc_seq_eval.sv
// Testbench for dtc_seq_eval: directed vectors, corner sequences and
// randomized trees checked against a behavioural tree-walk model.
module tb_dtc_seq_eval;

  localparam int MD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  inp;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_class;
  logic        out_err;
  logic [3:0]  out_depth;

  int tests = 0;
  int fails = 0;

  logic [15:0] mtab [32];

  typedef struct {
    logic [7:0] x;
    int         cls;
    int         dep;
    int         lat;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  dtc_seq_eval #(
    .INPUT_WIDTH(8),
    .CLASS_WIDTH(2),
    .MAX_NODES(32),
    .MAX_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err), .out_depth(out_depth)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: follow child pointers through the model table until a leaf,
  // a bad pointer or the depth limit is reached.
  function automatic void model_walk(input logic [7:0] x, output int cls,
                                     output int err, output int dep);
    int p;
    logic [15:0] w;
    logic [2:0]  f;
    p = 0; cls = 0; err = 0; dep = 0;
    for (int k = 0; k <= MD + 1; k++) begin
      if (p >= 32) begin err = 1; return; end
      w = mtab[p];
      if (w[15]) begin cls = int'(w[1:0]); return; end
      if (dep == MD) begin err = 1; return; end
      f = w[14:12];
      p = x[f] ? int'(w[11:7]) : int'(w[6:2]);
      dep++;
    end
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) mtab[i] = 16'h8000;
  endtask

  task automatic write_node(input logic [4:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mtab[a] = d;
  endtask

  task automatic start(input logic [7:0] x);
    in_valid = 1'b1; inp = x;
    @(posedge clk); #1;
    in_valid = 1'b0; inp = 8'($urandom);
  endtask

  task automatic wait_valid(output int lat, output logic ok);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = out_valid;
    if (!ok) check("out_valid_timeout", 0, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [7:0] x, output int cls, output int err,
                     output int dep, output int lat);
    logic ok;
    start(x);
    wait_valid(lat, ok);
    cls = out_class; err = out_err; dep = out_depth;
    if (ok) handshake();
  endtask

  initial begin
    int c, e, d, lat, mc, me, md, hold, seen;
    logic ok;
    vecs[0] = '{x: 8'h08, cls: 2, dep: 2, lat: 3};
    vecs[1] = '{x: 8'h48, cls: 3, dep: 2, lat: 3};
    vecs[2] = '{x: 8'h00, cls: 1, dep: 1, lat: 2};
    vecs[3] = '{x: 8'hF7, cls: 1, dep: 1, lat: 2};
    vecs[4] = '{x: 8'hBF, cls: 2, dep: 2, lat: 3};
    vecs[5] = '{x: 8'hFF, cls: 3, dep: 2, lat: 3};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; inp = '0; out_ready = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_cfg_busy", cfg_busy, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_depth", out_depth, 0);

    // Default table: root is a class-0 leaf
    run(8'hFF, c, e, d, lat);
    check("dflt_class", c, 0);
    check("dflt_err", e, 0);
    check("dflt_depth", d, 0);
    check("dflt_lat", lat, 1);

    write_node(5'd0, 16'h3104);
    write_node(5'd1, 16'h8001);
    write_node(5'd2, 16'h620C);
    write_node(5'd3, 16'h8002);
    write_node(5'd4, 16'h8003);
    foreach (vecs[i]) begin
      run(vecs[i].x, c, e, d, lat);
      check($sformatf("vec%0d_class", i), c, vecs[i].cls);
      check($sformatf("vec%0d_err", i), e, 0);
      check($sformatf("vec%0d_depth", i), d, vecs[i].dep);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Self-loop at the root aborts on the depth limit
    write_node(5'd0, 16'h0000);
    run(8'h5A, c, e, d, lat);
    check("loop_err", e, 1);
    check("loop_class", c, 0);
    check("loop_depth", d, MD);
    check("loop_lat", lat, MD + 1);

    // Backpressure in DONE with a dropped config write and ignored input
    write_node(5'd0, 16'h3104);
    start(8'h08);
    wait_valid(lat, ok);
    check("bp_lat", lat, 3);
    c = out_class; e = out_err; d = out_depth;
    check("bp_class", c, 2);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'h8003; end
      if (k == 2) begin in_valid = 1'b1; inp = 8'h48; end
      @(posedge clk); #1;
      cfg_we = 1'b0; in_valid = 1'b0;
      check($sformatf("bp%0d_valid", k), out_valid, 1);
      check($sformatf("bp%0d_class", k), out_class, c);
      check($sformatf("bp%0d_err", k), out_err, e);
      check($sformatf("bp%0d_depth", k), out_depth, d);
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
      check($sformatf("bp%0d_cfg_busy", k), cfg_busy, 1);
    end
    handshake();
    check("bp_post_in_ready", in_ready, 1);
    check("bp_post_valid", out_valid, 0);
    run(8'h08, c, e, d, lat);
    check("bp_oldtree_class", c, 2);
    check("bp_oldtree_depth", d, 2);

    // Config write during WALK is dropped too
    start(8'h48);
    cfg_we = 1'b1; cfg_addr = 5'd4; cfg_data = 16'h8000;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    wait_valid(lat, ok);
    if (ok) handshake();
    run(8'h48, c, e, d, lat);
    check("walkwr_class", c, 3);

    // Same-edge config write and accept: walk sees the new root
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'h8003;
    in_valid = 1'b1; inp = 8'h08;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    mtab[0] = 16'h8003;
    wait_valid(lat, ok);
    check("same_class", out_class, 3);
    check("same_depth", out_depth, 0);
    check("same_err", out_err, 0);
    check("same_lat", lat, 1);
    if (ok) handshake();

    // Randomized trees against the model, with random backpressure
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 32; i++) begin
        logic [15:0] w;
        logic [4:0]  c1, c0;
        if (i < 31 && $urandom_range(0, 99) < 80) begin
          c1 = 5'($urandom_range(i + 1, 31));
          c0 = 5'($urandom_range(i + 1, 31));
        end else begin
          c1 = 5'($urandom);
          c0 = 5'($urandom);
        end
        w = {($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0, 3'($urandom), c1, c0, 2'($urandom)};
        write_node(5'(i), w);
      end
      for (int n = 0; n < 20; n++) begin
        logic [7:0] x;
        x = 8'($urandom);
        model_walk(x, mc, me, md);
        start(x);
        wait_valid(lat, ok);
        c = out_class; e = out_err; d = out_depth;
        hold = $urandom_range(0, 3);
        repeat (hold) begin @(posedge clk); #1; end
        check("rnd_hold_class", out_class, c);
        check("rnd_class", c, mc);
        check("rnd_err", e, me);
        check("rnd_depth", d, md);
        check("rnd_lat", lat, md + 1);
        if (ok) handshake();
      end
    end

    // Mid-walk reset abandons the transaction and restores the table
    write_node(5'd0, 16'h0000);
    start(8'h33);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_cfg_busy", cfg_busy, 0);
    check("mrst_out_depth", out_depth, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mrst_no_valid", seen, 0);
    run(8'h55, c, e, d, lat);
    model_walk(8'h55, mc, me, md);
    check("mrst_class", c, mc);
    check("mrst_err", e, me);
    check("mrst_depth", d, md);
    check("mrst_lat", lat, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
